// File: rtl/pipeline_types.sv
// ============================================================================
// Module  : pipeline_types
// Brief   : Shared types and tick-timing defaults for the WS2812 receive path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_types;

    // Tick assumptions shared by the edge counter and the frame decoder
    localparam int unsigned DEFAULT_PRESCALE        = 5;
    localparam int unsigned DEFAULT_T1H_MIN_TICKS   = 6;
    localparam int unsigned DEFAULT_THIGH_MAX_TICKS = 20;
    localparam int unsigned DEFAULT_RESET_TICKS     = 500;
    localparam int unsigned COUNTER_W               = 10;
    localparam int unsigned PIXEL_BITS              = 24;

    typedef struct packed {
        logic rising;
        logic falling;
    } control_path_t;

    typedef struct packed {
        logic [COUNTER_W-1:0] counter;
    } decoder_input_t;

    typedef enum logic [1:0] {
        DS_SYNC = 2'd0,
        DS_IDLE = 2'd1,
        DS_HIGH = 2'd2,
        DS_LOW  = 2'd3
    } decoder_state_e;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef struct packed {
        pixel_t     pixel;
        logic       valid;
        logic [7:0] index;
        logic       frame_done;
        logic       error;
    } decoder_output_t;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module  : tick_prescaler
// Brief   : Free-running divider producing a registered one-cycle tick enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int unsigned PRESCALE = 5
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_count_enable
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] r_cnt;
    logic       r_enable;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt    <= 8'd0;
            r_enable <= 1'b0;
        end else begin
            r_enable <= (r_cnt == LAST);
            r_cnt    <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    assign o_count_enable = r_enable;

endmodule

`default_nettype wire

// File: rtl/ws2812_frame_decoder.sv
// ============================================================================
// Module  : ws2812_frame_decoder
// Brief   : Classifies WS2812 pulse widths, assembles GRB pixels, detects latch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_frame_decoder
    import pipeline_types::*;
#(
    parameter int unsigned PRESCALE        = DEFAULT_PRESCALE,
    parameter int unsigned T1H_MIN_TICKS   = DEFAULT_T1H_MIN_TICKS,
    parameter int unsigned THIGH_MAX_TICKS = DEFAULT_THIGH_MAX_TICKS,
    parameter int unsigned RESET_TICKS     = DEFAULT_RESET_TICKS
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_line,
    input  control_path_t  i_control,
    input  decoder_input_t i_decoder_input,
    output logic           o_count_enable,
    output logic [23:0]    o_pixel,
    output logic           o_pixel_valid,
    output logic [7:0]     o_pixel_index,
    output logic           o_frame_done,
    output logic           o_bit_error
);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [9:0] RESET_C = 10'(RESET_TICKS);
    localparam logic [9:0] T1H_C   = 10'(T1H_MIN_TICKS);
    localparam logic [9:0] TMAX_C  = 10'(THIGH_MAX_TICKS);

    logic [1:0]      r_state;
    logic [23:0]     r_shift;
    logic [4:0]      r_bit_cnt;
    logic [7:0]      r_pix_cnt;
    decoder_output_t r_out;

    logic [9:0]  w_count;
    logic        w_glitch;
    logic        w_latch;
    logic        w_width_err;
    logic [23:0] w_shift_next;

    assign w_count      = i_decoder_input.counter;
    assign w_glitch     = i_control.rising & i_control.falling;
    assign w_latch      = (w_count >= RESET_C);
    assign w_width_err  = (w_count > TMAX_C);
    assign w_shift_next = {r_shift[22:0], (w_count >= T1H_C)};

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .o_count_enable (o_count_enable)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_SYNC;
            r_shift   <= 24'd0;
            r_bit_cnt <= 5'd0;
            r_pix_cnt <= 8'd0;
            r_out     <= '0;
        end else begin
            r_out.valid      <= 1'b0;
            r_out.frame_done <= 1'b0;
            r_out.error      <= 1'b0;
            // Losing sync also drops the frame position so resync starts clean
            if (r_state != ST_SYNC && w_glitch) begin
                r_out.error <= 1'b1;
                r_state     <= ST_SYNC;
                r_shift     <= 24'd0;
                r_bit_cnt   <= 5'd0;
                r_pix_cnt   <= 8'd0;
            end else begin
                case (r_state)
                    ST_SYNC: begin
                        if (!i_line && w_latch) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (i_control.rising) begin
                            r_state <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (i_control.falling && w_width_err) begin
                            r_out.error <= 1'b1;
                            r_state     <= ST_SYNC;
                            r_shift     <= 24'd0;
                            r_bit_cnt   <= 5'd0;
                            r_pix_cnt   <= 8'd0;
                        end else if (i_control.falling) begin
                            r_state <= ST_LOW;
                            if (r_bit_cnt == 5'd23) begin
                                r_out.pixel <= w_shift_next;
                                r_out.index <= r_pix_cnt;
                                r_out.valid <= 1'b1;
                                r_shift     <= 24'd0;
                                r_bit_cnt   <= 5'd0;
                                r_pix_cnt   <= (r_pix_cnt == 8'hFF) ? r_pix_cnt : r_pix_cnt + 8'd1;
                            end else begin
                                r_shift   <= w_shift_next;
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end else if (w_count[9]) begin
                            r_out.error <= 1'b1;
                            r_state     <= ST_SYNC;
                            r_shift     <= 24'd0;
                            r_bit_cnt   <= 5'd0;
                            r_pix_cnt   <= 8'd0;
                        end
                    end
                    ST_LOW: begin
                        if (i_control.rising) begin
                            r_state <= ST_HIGH;
                        end else if (w_latch) begin
                            r_out.frame_done <= 1'b1;
                            r_out.error      <= (r_bit_cnt != 5'd0);
                            r_state          <= ST_IDLE;
                            r_shift          <= 24'd0;
                            r_bit_cnt        <= 5'd0;
                            r_pix_cnt        <= 8'd0;
                        end
                    end
                    default: begin
                        r_state <= ST_SYNC;
                    end
                endcase
            end
        end
    end

    assign o_pixel       = r_out.pixel;
    assign o_pixel_valid = r_out.valid;
    assign o_pixel_index = r_out.index;
    assign o_frame_done  = r_out.frame_done;
    assign o_bit_error   = r_out.error;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_frame_decoder.sv
// ============================================================================
// Module  : tb_ws2812_frame_decoder
// Brief   : Randomized self-checking bench with a protocol-level pixel model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws2812_frame_decoder;
    import pipeline_types::*;

    localparam int P = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           line = 1'b0;
    control_path_t  ctrl = '0;
    decoder_input_t din = '0;
    logic           en;
    logic [23:0]    pix;
    logic           pv;
    logic [7:0]     pidx_o;
    logic           fd;
    logic           be;

    always #10 clk = ~clk;

    ws2812_frame_decoder dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_line          (line),
        .i_control       (ctrl),
        .i_decoder_input (din),
        .o_count_enable  (en),
        .o_pixel         (pix),
        .o_pixel_valid   (pv),
        .o_pixel_index   (pidx_o),
        .o_frame_done    (fd),
        .o_bit_error     (be)
    );

    int cyc = 0, rel = 0, n_checks = 0, n_fail = 0;
    int n_valid = 0, n_done = 0, n_err = 0, n_done_err = 0;
    logic [23:0] last_pix = '0;
    int          last_idx = 0;

    // Expected strobes keyed by the cycle in which they must be visible
    bit          exp_v[int];
    logic [23:0] exp_p[int];
    int          exp_i[int];
    bit          exp_d[int];
    bit          exp_e[int];

    // Protocol-level model: sync status, bits of the pixel in flight, frame position
    bit          synced = 0;
    bit          in_frame = 0;
    int          nbits = 0;
    logic [23:0] acc = '0;
    int          pidx = 0;
    int          prev_low = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (rst_n) rel = rel + 1; else rel = 0;
        #1;
        if (!rst_n) begin
            check("reset_outputs", {en, pv, fd, be, pix, pidx_o}, 0);
        end else begin
            check("count_enable", en, (rel % P) == 0);
            check("pixel_valid", pv, exp_v.exists(cyc));
            check("frame_done", fd, exp_d.exists(cyc));
            check("bit_error", be, exp_e.exists(cyc));
            if (exp_v.exists(cyc)) begin
                check("pixel", pix, exp_p[cyc]);
                check("pixel_index", pidx_o, exp_i[cyc]);
            end
            if (pv) begin n_valid++; last_pix = pix; last_idx = pidx_o; end
            if (fd) n_done++;
            if (be) n_err++;
            if (fd && be) n_done_err++;
        end
    end

    task automatic drive(input logic ln, input logic r, input logic f, input int c);
        @(negedge clk);
        line = ln;
        ctrl.rising = r;
        ctrl.falling = f;
        din.counter = (c > 1023) ? 10'd1023 : 10'(c);
    endtask

    task automatic desync();
        synced = 0; in_frame = 0; nbits = 0; acc = '0; pidx = 0;
    endtask

    task automatic low(input int ticks);
        for (int k = 0; k < ticks * P; k++) begin
            drive(1'b0, 1'b0, 1'b0, k / P);
            if (k / P >= 500 && rst_n) begin
                if (!synced) synced = 1;
                else if (in_frame) begin
                    exp_d[cyc + 1] = 1;
                    if (nbits != 0) exp_e[cyc + 1] = 1;
                    in_frame = 0; nbits = 0; acc = '0; pidx = 0;
                end
            end
        end
        prev_low = ticks;
    endtask

    task automatic high_pulse(input int h);
        drive(1'b1, 1'b1, 1'b0, prev_low);
        for (int k = 0; k < h * P; k++) begin
            drive(1'b1, 1'b0, 1'b0, k / P);
            if (synced && k / P >= 512) begin
                exp_e[cyc + 1] = 1;
                desync();
            end
        end
        drive(1'b0, 1'b0, 1'b1, h);
        if (synced) begin
            if (h > 20) begin
                exp_e[cyc + 1] = 1;
                desync();
            end else begin
                acc = {acc[22:0], (h >= 6)};
                nbits++;
                in_frame = 1;
                if (nbits == 24) begin
                    exp_v[cyc + 1] = 1;
                    exp_p[cyc + 1] = acc;
                    exp_i[cyc + 1] = pidx;
                    if (pidx < 255) pidx++;
                    nbits = 0;
                end
            end
        end else if (h >= 500) begin
            synced = 1;
        end
    endtask

    task automatic send_bit(input int h, input int l);
        high_pulse(h);
        low(l);
    endtask

    task automatic rand_bit();
        if ($urandom_range(1, 0) == 1) send_bit($urandom_range(12, 6), $urandom_range(6, 1));
        else send_bit($urandom_range(5, 1), $urandom_range(6, 1));
    endtask

    task automatic send_pixel(input logic [23:0] v, input bit rnd);
        for (int i = 23; i >= 0; i--) begin
            if (rnd) send_bit(v[i] ? $urandom_range(12, 6) : $urandom_range(5, 1), $urandom_range(6, 1));
            else send_bit(v[i] ? 8 : 4, 8);
        end
    endtask

    task automatic glitch();
        drive(1'b0, 1'b1, 1'b1, 3);
        if (synced) begin
            exp_e[cyc + 1] = 1;
            desync();
        end
    endtask

    int e0, v0, d0;

    initial begin
        repeat (3) drive(1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;

        low(520);
        check("no_strobes_during_sync", n_valid + n_done + n_err, 0);

        send_pixel(24'hA5C30F, 0);
        check("first_pixel_literal", last_pix, 24'hA5C30F);
        check("first_index_literal", last_idx, 0);
        send_pixel(24'($urandom), 1);
        send_pixel(24'($urandom), 1);
        low(550);
        check("frame_done_count", n_done, 1);
        check("third_index", last_idx, 2);

        send_pixel(24'($urandom), 1);
        check("restart_index", last_idx, 0);
        low(505);

        send_bit(5, 8);
        send_bit(6, 8);
        send_bit(20, 8);
        repeat (21) send_bit(5, 4);
        check("boundary_pixel", last_pix, 24'h600000);
        low(505);
        e0 = n_err; v0 = n_valid;
        send_bit(21, 8);
        check("wide_high_error", n_err - e0, 1);
        low(505);
        check("no_pixel_after_error", n_valid - v0, 0);

        repeat (10) rand_bit();
        v0 = n_valid;
        low(550);
        check("partial_done_with_error", n_done_err, 1);
        check("partial_no_pixel", n_valid - v0, 0);

        repeat (5) rand_bit();
        e0 = n_err; d0 = n_done;
        glitch();
        low(505);
        check("glitch_error", n_err - e0, 1);
        check("glitch_no_frame_done", n_done - d0, 0);
        send_pixel(24'($urandom), 1);
        check("index_after_glitch", last_idx, 0);
        low(505);

        e0 = n_err;
        high_pulse(515);
        low(20);
        check("saturation_error", n_err - e0, 1);
        send_pixel(24'($urandom), 1);
        low(505);

        repeat (7) rand_bit();
        drive(1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        desync();
        repeat (3) drive(1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        low(505);
        send_pixel(24'($urandom), 1);
        check("index_after_reset", last_idx, 0);
        low(505);

        for (int f = 0; f < 2; f++) begin
            int np;
            np = $urandom_range(2, 1);
            for (int p = 0; p < np; p++) send_pixel(24'($urandom), 1);
            if ($urandom_range(1, 0) == 1) repeat ($urandom_range(4, 1)) rand_bit();
            low(505);
        end

        repeat (5) drive(1'b0, 1'b0, 1'b0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ws2812_frame_decoder.md
Name: ws2812_frame_decoder

Overview:
- Sequencing controller for the WS2812 receive pipeline's edge-duration counter.
- Generates the counter's tick enable and samples the counter value on each edge.
- Classifies high-pulse widths as 0/1 bits, assembles 24-bit GRB pixels MSB-first, and detects the low-time latch (reset) that ends a frame.
- Sits between the edge detector/counter stage and the downstream pixel consumer.

Parameters:
- PRESCALE, 5, clocks per counter tick (50 MHz clock gives a 100 ns tick); legal values 1..255.
- T1H_MIN_TICKS, 6, high width at or above this many ticks decodes as 1; below it decodes as 0.
- THIGH_MAX_TICKS, 20, high width above this many ticks is a bit error.
- RESET_TICKS, 500, low width at or above this many ticks is the frame latch; must be at most 511.

Ports:
- i_clk, in, 1: clock.
- i_reset_n, in, 1: reset, asynchronous, active-low.
- i_line, in, 1: synchronized WS2812 data-line level.
- i_control, in, control_path_t: edge flags .rising and .falling, each a single-cycle pulse.
- i_decoder_input, in, decoder_input_t: .counter[9:0], the tick count since the last edge.
- o_count_enable, out, 1: tick enable driven to the counter.
- o_pixel, out, 24: last completed pixel, GRB order, MSB first.
- o_pixel_valid, out, 1: one-cycle strobe; o_pixel is new.
- o_pixel_index, out, 8: index of the pixel in o_pixel within the current frame.
- o_frame_done, out, 1: one-cycle strobe on latch detection.
- o_bit_error, out, 1: one-cycle strobe on a timing or protocol error.

Behaviour:
- Reset values:
  - All outputs 0.
  - Prescaler 0, FSM in SYNC, shift register 0, bit count 0, pixel count 0.
  - Reset mid-frame discards the partial pixel and raises no strobes.
- Prescaler:
  - Free-running 0..PRESCALE-1.
  - o_count_enable is registered and high for exactly one cycle per PRESCALE cycles.
  - With PRESCALE=1, o_count_enable is constantly high from the first cycle after reset.
- Counter semantics:
  - In the cycle an edge flag is high, i_decoder_input.counter holds the duration of the preceding level.
  - The decoder samples it in that same cycle.
- FSM states and transitions:
  - SYNC: wait for i_line=0 and counter >= RESET_TICKS, then go to IDLE. No strobes. Edges are ignored.
  - IDLE: rising goes to HIGH. counter >= RESET_TICKS while in IDLE produces no repeat frame_done.
  - HIGH: on falling, width w = counter.
    - w < T1H_MIN_TICKS shifts in 0.
    - T1H_MIN_TICKS <= w <= THIGH_MAX_TICKS shifts in 1.
    - w > THIGH_MAX_TICKS raises bit_error and goes to SYNC.
    - Valid bits go to LOW.
    - Counter reaching saturation (bit 9) while in HIGH raises bit_error and goes to SYNC.
  - LOW:
    - Rising goes to HIGH.
    - counter >= RESET_TICKS with bit count 0 raises frame_done, clears pixel count, goes to IDLE.
    - counter >= RESET_TICKS with bit count not 0 raises bit_error and frame_done, discards the partial pixel, clears pixel count, goes to IDLE.
- Pixel assembly:
  - Shift left, new bit at LSB.
  - On the 24th bit, o_pixel and o_pixel_index (pre-increment value) are registered and o_pixel_valid pulses.
  - This happens the cycle after the falling-edge cycle, i.e. latency 1.
  - Bit count then returns to 0 and pixel count increments.
  - Pixel count saturates at 255; later pixels still emit with index 255.
- Simultaneous rising and falling in one cycle is a glitch in every state except SYNC: raise bit_error and go to SYNC.
- Strobes are registered; at most one of each per cycle.

Decomposition:
- pipeline_types gains:
  - decoder_state_e (SYNC, IDLE, HIGH, LOW).
  - pixel_t (24-bit packed struct with g, r, b bytes).
  - decoder_output_t bundling pixel, valid, index, frame_done, error.
- Timing defaults become localparams in pipeline_types so the counter and decoder share tick assumptions.
- One sub-module, tick_prescaler, generates o_count_enable.
- The FSM, shifter and pixel counter stay in the top.

Test Plan:
- Reset release, line low 52 us -> SYNC to IDLE; o_count_enable pulses every 5 clocks; no strobes.
- 24 bits of 0xA5C30F with highs of 4 ticks (0) and 8 ticks (1), lows of 8 ticks -> o_pixel=0xA5C30F, o_pixel_valid one cycle after the 24th falling edge, o_pixel_index=0.
- Three pixels then 55 us low -> indexes 0, 1, 2; o_frame_done one pulse; next frame restarts at index 0.
- Boundary widths: high 5 ticks -> 0; 6 ticks -> 1; 20 ticks -> 1; 21 ticks -> bit_error and SYNC, no pixel emitted.
- 10 bits then 55 us low -> bit_error and frame_done in the same cycle, no pixel_valid.
- rising and falling asserted together mid-pixel -> bit_error, SYNC; next latch period then accepts a clean pixel. Assert i_reset_n low mid-pixel -> all outputs 0, no strobes.
